// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with a single full-adder cell, carry flop and signed overflow
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sa, sb, acc;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sh;
  logic c, s, co, last;
  always_comb begin
    s = sa[0] ^ sb[0] ^ c;
    co = (sa[0] & sb[0]) | ((sa[0] ^ sb[0]) & c);
    sh = {s, acc};
    last = cnt == CW'(WIDTH - 1);
    state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // c holds the carry into the bit being processed, so on the last bit it is the carry into the MSB
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sa <= '0;
      sb <= '0;
      acc <= '0;
      c <= 1'b0;
      cnt <= '0;
      z <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      sa <= a;
      sb <= b;
      c <= cin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      acc <= sh[WIDTH:1];
      c <= co;
      cnt <= last ? cnt : cnt + 1'b1;
      if (last) begin
        z <= sh[WIDTH:1];
        cout <= co;
        ovf <= c ^ co;
      end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random scoreboard bench for serial_adder
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout, ovf;
  logic [W-1:0] z;
  int tests = 0, fails = 0;
  logic [W+1:0] q[$];
  logic [W+1:0] last = '0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .z(z), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] s;
    logic o;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    o = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {s[W-1:0], s[W], o};
  endfunction

  // Monitor: results only move on a done cycle and must match the scoreboard head
  always @(negedge clk) begin
    if (reset) begin
      last = '0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("busy_after_done", {31'd0, busy}, 32'd0);
      if (done) begin
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got z=%h cout=%b ovf=%b expected no done", z, cout, ovf);
        end else begin
          last = q.pop_front();
          chk("result", {22'd0, z, cout, ovf}, {22'd0, last});
        end
      end else chk("hold", {22'd0, z, cout, ovf}, {22'd0, last});
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL timeout_idle: got busy=1 expected busy=0 within 100 cycles");
    end
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    @(negedge clk);
    wait_idle();
    a = x;
    b = y;
    cin = ci;
    start = 1'b1;
    q.push_back(model(x, y, ci));
    @(negedge clk);
    start = 1'b0;
    a = ~x;
    b = W'($urandom);
    cin = ~ci;
  endtask

  initial begin
    int k;
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_z", {24'd0, z}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    op(8'h0F, 8'h01, 1'b0);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, W);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'h7F, 8'h01, 1'b0);
    op(8'h00, 8'h00, 1'b1);
    op(8'h80, 8'h80, 1'b0);
    op(8'hFF, 8'hFF, 1'b1);
    op(8'h12, 8'h34, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    op(8'h5A, 8'h33, 1'b1);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_z", {24'd0, z}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    void'(q.pop_back());
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    #1 chk("start_in_reset_ignored", {31'd0, busy}, 32'd0);
    repeat (12) @(negedge clk);
    op(8'h5A, 8'h33, 1'b1);
    for (int i = 0; i < 256; i++) op(W'($urandom), W'($urandom), i[0] ^ i[3]);
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain", q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an addition; sampled on rising edge of clk.
REQ-005 a  input  WIDTH  first operand; sampled only on an accepted start.
REQ-006 b  input  WIDTH  second operand; sampled only on an accepted start.
REQ-007 cin  input  1  carry-in; sampled only on an accepted start.
REQ-008 busy  output  1  high while an addition is in progress (states RUN and DONE).
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 z  output  WIDTH  registered sum.
REQ-011 cout  output  1  registered carry-out of the MSB.
REQ-012 ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 The block SHALL compute {cout,z} = a + b + cin one bit per cycle, LSB first, using a single 1-bit full-adder cell (sum = a^b^c; carry = a&b | (a^b)&c) and a carry flip-flop.
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE: busy=0, done=0; start=1 at a rising edge SHALL load a and b into operand shift registers, load cin into the carry flop, clear the bit counter, and go to RUN.
REQ-016 IDLE with start=0 SHALL remain in IDLE; outputs z, cout and ovf hold their values.
REQ-017 RUN: each rising edge SHALL add the operand LSBs and the carry, shift the sum bit into the internal result shift register from the MSB end, store the new carry, shift both operands right by one, and increment the bit counter.
REQ-018 On the RUN edge that processes bit WIDTH-1, the block SHALL load the complete sum into z, the final carry into cout, the ovf value into ovf, and go to DONE.
REQ-019 ovf SHALL be computed from the carry into bit WIDTH-1 and the carry out of bit WIDTH-1; for WIDTH=1, carry-in to the MSB is cin.
REQ-020 DONE: done=1 and busy=1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-021 Latency: if start is accepted at edge N, done SHALL be high during the cycle after edge N+WIDTH; the next start is accepted no earlier than edge N+WIDTH+2.
REQ-022 start while in RUN or DONE SHALL be ignored and SHALL NOT disturb the operands, the carry or the result.
REQ-023 z, cout and ovf SHALL show no partial results; they change only on the RUN-to-DONE edge or on reset.
REQ-024 Changes on a, b or cin after acceptance SHALL NOT affect the result in progress.
REQ-025 The bit counter SHALL be wide enough for WIDTH-1 and SHALL NOT wrap during RUN.

Reset
REQ-026 Asserting reset SHALL immediately force the state to IDLE and set busy=0, done=0, z=0, cout=0 and ovf=0, and clear the shift registers, carry flop and counter, without waiting for clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse for that operation SHALL follow deassertion.
REQ-028 While reset is high, start SHALL be ignored; the first start is accepted on the first rising edge with reset low.

Verification (WIDTH=8)
REQ-029 Reset pulse with no clock edge -> busy=0, done=0, z=8'h00, cout=0, ovf=0 immediately.
REQ-030 a=8'h0F, b=8'h01, cin=0, start at edge N -> done high for exactly one cycle after edge N+8, z=8'h10, cout=0, ovf=0.
REQ-031 a=8'hFF, b=8'h01, cin=0 -> z=8'h00, cout=1, ovf=0; a=8'h7F, b=8'h01, cin=0 -> z=8'h80, cout=0, ovf=1; a=8'h00, b=8'h00, cin=1 -> z=8'h01, cout=0.
REQ-032 Start a=8'h12, b=8'h34; at edge N+3, pulse start with a=8'hFF, b=8'hFF -> ignored; z=8'h46, cout=0; only one done pulse.
REQ-033 Start an operation, assert reset at edge N+4 -> busy=0, z=8'h00 at once; no done pulse follows; the next start gives the correct sum.
REQ-034 Back-to-back random operands (at least 256 operations, including all carry-in values) -> every z, cout and ovf matches a+b+cin computed by the bench; busy low in the cycle after each done.
